matmul_run_sequencer: RTL
=========================

# matmul_run_sequencer

Run controller for the matrix-multiplier HLS core. It waits out a power-up delay, then runs the core repeatedly. Each run it issues the ap_ctrl_hs start handshake, streams a fixed A/B operand frame into `input_r`, drains the result frame from `output_r` and checks its framing. The operand pattern is chosen so that every correct result word equals `A_VALUE*B_VALUE*DIM` (12 with the defaults); the downstream result checker relies on this.

## Interface
- `START_DELAY`, 20'd20000: cycles after reset before the first run.
- `DIM`, 3'd4: matrix dimension. Input frame is 2*DIM*DIM words; output frame is DIM*DIM words.
- `A_VALUE`, 32'd1: value of every A word.
- `B_VALUE`, 32'd3: value of every B word.
- `NUM_RUNS`, 8'd0: number of runs; 0 means run forever.
- `GAP_CYCLES`, 8'd16: idle cycles between runs.
- `TIMEOUT`, 16'd4096: cycles with no handshake before a run is aborted.
- `clk`  in  1  single clock.
- `reset`  in  1  **asynchronous, active-high** reset.
- `ap_start`  out  1  core start.
- `ap_ready`  in  1  core has accepted start.
- `ap_done`  in  1  core finished.
- `input_r_TDATA`  out  32  operand word.
- `input_r_TVALID`  out  1
- `input_r_TLAST`  out  1
- `input_r_TREADY`  in  1
- `output_r_TDATA`  in  32  result word (not inspected here).
- `output_r_TVALID`  in  1
- `output_r_TLAST`  in  1
- `output_r_TREADY`  out  1
- `run_count`  out  8  completed runs; saturates at 255.
- `busy`  out  1  high in SEND and DRAIN.
- `framing_error`  out  1  sticky.
- `timeout_error`  out  1  sticky.

## Operation
- States: DELAY, SEND, DRAIN, GAP, HALT.
- **DELAY**
  - A 20-bit counter increments from 0.
  - When it reaches START_DELAY-1, go to SEND. ap_start, input_r_TVALID and beat counters are set on entry.
- **SEND**
  - ap_start stays high until ap_ready is sampled high, then drops. This is independent of streaming progress.
  - input_r_TVALID is high throughout SEND. A beat transfers when TVALID and TREADY are both high.
  - Beat index i counts 0..2*DIM*DIM-1.
  - TDATA = A_VALUE for i < DIM*DIM, otherwise B_VALUE.
  - TLAST is high only on i = 2*DIM*DIM-1.
  - TDATA and TLAST hold while TREADY is low.
  - After the last beat transfers, go to DRAIN.
- **Output side (SEND and DRAIN)**
  - output_r_TREADY is high; it is low in all other states.
  - The output beat counter o increments on each TVALID&TREADY beat.
  - ap_done is latched into done_seen.
- **Framing check**
  - framing_error is set if TLAST=1 on a beat with o ≠ DIM*DIM-1.
  - framing_error is also set if TLAST=0 on beat o = DIM*DIM-1.
  - Beats beyond DIM*DIM also set framing_error.
- **Run completion**: in DRAIN, once o has reached DIM*DIM and done_seen=1, run_count increments (saturating) and the state goes to GAP.
- **Watchdog**
  - A 16-bit counter runs in SEND and DRAIN. It clears on any input beat, output beat, or ap_ready/ap_done pulse.
  - On reaching TIMEOUT, set timeout_error, drop all valid/ready/start outputs, and go to HALT.
- **GAP**: wait GAP_CYCLES. Then, if NUM_RUNS==0 or run_count < NUM_RUNS, go to SEND (new run); otherwise go to HALT.
- **HALT**: terminal. All handshake outputs stay low until reset.
- Error flags are never cleared except by reset.

## Timing
- **Reset (async assert)**: state=DELAY, all counters 0. Every output is 0: ap_start, input_r_*, output_r_TREADY, run_count, busy, framing_error, timeout_error. Reset release is synchronous to clk.
- **Registered outputs**: all outputs are registered and change only on clk edges.
- **First run**: ap_start and input_r_TVALID rise together, START_DELAY cycles after the first clk edge with reset low.
- **Back-to-back beats**: with TREADY held high, one input beat transfers per cycle. The minimum input frame is 2*DIM*DIM cycles.
- **Simultaneous events**
  - ap_ready and the last input beat in the same cycle: ap_start drops and the state enters DRAIN on the same edge.
  - ap_done before the last output beat: it is latched, and completion occurs on the edge after the final output beat.
  - Output beats during SEND are counted normally.
- **Reset mid-run**: outputs go low immediately. The sequence restarts at DELAY with a full START_DELAY wait.
- **busy**: high from the edge entering SEND to the edge leaving DRAIN.

## Test plan
- **Nominal run**: START_DELAY=20, NUM_RUNS=1. A responsive core model returns 16 words of 12 with TLAST on beat 15.
  - ap_start rises at cycle 20.
  - 16 words of 1, then 16 words of 3, with TLAST on beat 31.
  - run_count=1, then HALT, with no error flags.
- **Input backpressure**: random input_r_TREADY at 50% duty. Required: TDATA/TLAST stable while stalled, exactly 32 beats, correct A/B split.
- **ap_done early**: assert ap_done 5 cycles before the last output beat. Required: the run completes on the edge after output beat 15; run_count increments by 1.
- **Framing faults**:
  - TLAST on output beat 7: framing_error=1.
  - Separate test, no TLAST on beat 15: framing_error=1.
  - In both cases sequencing continues.
- **Stalled core**: input_r_TREADY held at 0, TIMEOUT=100. Required: timeout_error=1 after 100 idle cycles, all handshake outputs 0, state HALT.
- **Repeat and reset**:
  - NUM_RUNS=0, GAP_CYCLES=4: runs repeat with 4-cycle gaps, and run_count increments on each run.
  - Assert reset during a SEND: all outputs 0 within the same cycle, and the next ap_start comes START_DELAY cycles after release.

Source files
------------

// File: rtl/matmul_run_sequencer.sv
// matmul_run_sequencer
//   Run controller for the matrix-multiplier HLS core. After a power-up delay
//   it repeatedly starts the core (ap_ctrl_hs), streams a constant A/B operand
//   frame into input_r, drains the result frame from output_r and checks its
//   TLAST framing. Every correct result word equals A_VALUE*B_VALUE*DIM.
//
// Ports
//   clk, reset         : single clock, asynchronous active-high reset
//   ap_start/ready/done: core start handshake
//   input_r_*          : AXI-Stream operand master (TDATA/TVALID/TLAST out, TREADY in)
//   output_r_*         : AXI-Stream result slave (TDATA/TVALID/TLAST in, TREADY out)
//   run_count          : completed runs, saturating at 255
//   busy               : high while in SEND or DRAIN
//   framing_error      : sticky, bad TLAST placement or excess result beats
//   timeout_error      : sticky, watchdog expired and the sequencer halted
`timescale 1ns/1ps
module matmul_run_sequencer #(
  parameter logic [19:0] START_DELAY = 20'd20000,
  parameter logic [2:0]  DIM         = 3'd4,
  parameter logic [31:0] A_VALUE     = 32'd1,
  parameter logic [31:0] B_VALUE     = 32'd3,
  parameter logic [7:0]  NUM_RUNS    = 8'd0,
  parameter logic [7:0]  GAP_CYCLES  = 8'd16,
  parameter logic [15:0] TIMEOUT     = 16'd4096
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ap_start,
  input  logic        ap_ready,
  input  logic        ap_done,
  output logic [31:0] input_r_TDATA,
  output logic        input_r_TVALID,
  output logic        input_r_TLAST,
  input  logic        input_r_TREADY,
  input  logic [31:0] output_r_TDATA,
  input  logic        output_r_TVALID,
  input  logic        output_r_TLAST,
  output logic        output_r_TREADY,
  output logic [7:0]  run_count,
  output logic        busy,
  output logic        framing_error,
  output logic        timeout_error
);

  localparam logic [7:0] DIM8  = {5'd0, DIM};
  localparam logic [7:0] N_OUT = DIM8 * DIM8;
  localparam logic [7:0] N_IN  = N_OUT + N_OUT;

  typedef enum logic [2:0] {S_DELAY, S_SEND, S_DRAIN, S_GAP, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [19:0] dly_cnt_q, dly_cnt_d;
  logic [7:0]  in_idx_q, in_idx_d;
  logic [7:0]  out_cnt_q, out_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] wd_q, wd_d;
  logic [7:0]  run_count_q, run_count_d;
  logic        done_seen_q, done_seen_d;
  logic        ap_start_q, ap_start_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        out_tready_q, out_tready_d;
  logic        busy_q, busy_d;
  logic        ferr_q, ferr_d;
  logic        terr_q, terr_d;

  logic in_beat, out_beat, activity, start_run;

  // Result payload is checked downstream, not here.
  logic unused_tdata;
  assign unused_tdata = ^output_r_TDATA;

  always_comb begin
    state_d      = state_q;
    dly_cnt_d    = dly_cnt_q;
    in_idx_d     = in_idx_q;
    out_cnt_d    = out_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    wd_d         = wd_q;
    run_count_d  = run_count_q;
    done_seen_d  = done_seen_q;
    ap_start_d   = ap_start_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    out_tready_d = out_tready_q;
    busy_d       = busy_q;
    ferr_d       = ferr_q;
    terr_d       = terr_q;
    start_run    = 1'b0;

    in_beat  = tvalid_q & input_r_TREADY;
    out_beat = out_tready_q & output_r_TVALID;
    activity = in_beat | out_beat | ap_ready | ap_done;

    case (state_q)
      S_DELAY: begin
        if ({1'b0, dly_cnt_q} + 21'd1 >= {1'b0, START_DELAY}) start_run = 1'b1;
        else dly_cnt_d = dly_cnt_q + 20'd1;
      end

      S_SEND, S_DRAIN: begin
        if (ap_start_q && ap_ready) ap_start_d = 1'b0;
        if (ap_done) done_seen_d = 1'b1;

        if (out_beat) begin
          if (out_cnt_q >= N_OUT) ferr_d = 1'b1;
          else if (output_r_TLAST != (out_cnt_q == N_OUT - 8'd1)) ferr_d = 1'b1;
          if (out_cnt_q != 8'hFF) out_cnt_d = out_cnt_q + 8'd1;
        end

        if (state_q == S_SEND && in_beat) begin
          if (in_idx_q == N_IN - 8'd1) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            state_d  = S_DRAIN;
          end else begin
            in_idx_d = in_idx_q + 8'd1;
            tdata_d  = (in_idx_q + 8'd1 < N_OUT) ? A_VALUE : B_VALUE;
            tlast_d  = (in_idx_q + 8'd1 == N_IN - 8'd1);
          end
        end

        wd_d = activity ? '0 : wd_q + 16'd1;

        // Completion uses registered count/done so it lands one edge after
        // the final result beat; it takes priority over the watchdog.
        if (state_q == S_DRAIN && out_cnt_q >= N_OUT && done_seen_q) begin
          if (run_count_q != 8'hFF) run_count_d = run_count_q + 8'd1;
          state_d      = S_GAP;
          gap_cnt_d    = '0;
          busy_d       = 1'b0;
          out_tready_d = 1'b0;
          ap_start_d   = 1'b0;
        end else if (!activity && ({1'b0, wd_q} + 17'd1 >= {1'b0, TIMEOUT})) begin
          terr_d       = 1'b1;
          state_d      = S_HALT;
          ap_start_d   = 1'b0;
          tvalid_d     = 1'b0;
          tlast_d      = 1'b0;
          tdata_d      = '0;
          out_tready_d = 1'b0;
          busy_d       = 1'b0;
        end
      end

      S_GAP: begin
        if ({1'b0, gap_cnt_q} + 9'd1 >= {1'b0, GAP_CYCLES}) begin
          if (NUM_RUNS == 8'd0 || run_count_q < NUM_RUNS) start_run = 1'b1;
          else state_d = S_HALT;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      S_HALT: ;

      default: state_d = S_HALT;
    endcase

    if (start_run) begin
      state_d      = S_SEND;
      dly_cnt_d    = '0;
      ap_start_d   = 1'b1;
      tvalid_d     = 1'b1;
      tdata_d      = A_VALUE;
      tlast_d      = 1'b0;
      in_idx_d     = '0;
      out_cnt_d    = '0;
      done_seen_d  = 1'b0;
      wd_d         = '0;
      busy_d       = 1'b1;
      out_tready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_DELAY;
      dly_cnt_q    <= '0;
      in_idx_q     <= '0;
      out_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      wd_q         <= '0;
      run_count_q  <= '0;
      done_seen_q  <= 1'b0;
      ap_start_q   <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      out_tready_q <= 1'b0;
      busy_q       <= 1'b0;
      ferr_q       <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_cnt_q    <= dly_cnt_d;
      in_idx_q     <= in_idx_d;
      out_cnt_q    <= out_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      wd_q         <= wd_d;
      run_count_q  <= run_count_d;
      done_seen_q  <= done_seen_d;
      ap_start_q   <= ap_start_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      out_tready_q <= out_tready_d;
      busy_q       <= busy_d;
      ferr_q       <= ferr_d;
      terr_q       <= terr_d;
    end
  end

  assign ap_start        = ap_start_q;
  assign input_r_TDATA   = tdata_q;
  assign input_r_TVALID  = tvalid_q;
  assign input_r_TLAST   = tlast_q;
  assign output_r_TREADY = out_tready_q;
  assign run_count       = run_count_q;
  assign busy            = busy_q;
  assign framing_error   = ferr_q;
  assign timeout_error   = terr_q;

endmodule
